// File: rtl/nabp_shift_controller.sv
// Shift sequencer for one projection line: it gives a kick, then kShiftCount shifts, then done.
// Optional NABP_SHIFT_ABORT_EN adds sc_abort, which closes a line early.
module nabp_shift_controller #(
    parameter int kShiftCount = 256,
    parameter int kCountWidth = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sc_start,
    input  logic                   sc_stall,
`ifdef NABP_SHIFT_ABORT_EN
    input  logic                   sc_abort,
`endif
    output logic                   sh_kick,
    output logic                   sh_shift_en,
    output logic                   sh_done,
    output logic                   sh_busy,
    output logic [kCountWidth-1:0] sh_shift_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        KICK,
        SHIFT,
        DONE
    } state_t;

    localparam logic [kCountWidth-1:0] kLast = kCountWidth'(kShiftCount - 1);

    state_t                 state;
    state_t                 state_nx;
    logic [kCountWidth-1:0] cnt;
    logic [kCountWidth-1:0] cnt_nx;
    logic                   abort;

`ifdef NABP_SHIFT_ABORT_EN
    assign abort = sc_abort;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The counter is cleared on entry to KICK, so it reads 0 for the whole line opening
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        sh_kick     = 1'b0;
        sh_shift_en = 1'b0;
        sh_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sc_start) begin
                    state_nx = KICK;
                    cnt_nx   = '0;
                end
            end
            KICK: begin
                sh_kick  = 1'b1;
                cnt_nx   = '0;
                state_nx = abort ? DONE : SHIFT;
            end
            SHIFT: begin
                if (abort) begin
                    state_nx = DONE;
                end else if (!sc_stall) begin
                    sh_shift_en = 1'b1;
                    cnt_nx      = cnt + 1'b1;
                    if (cnt == kLast) state_nx = DONE;
                end
            end
            DONE: begin
                sh_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sh_busy      = (state != IDLE);
    assign sh_shift_cnt = cnt;

endmodule

// File: tb/tb_nabp_shift_controller.sv
// Directed bench for nabp_shift_controller with kShiftCount=8. It drives inputs from a vector table and from hand-written sequences.
// The abort sequence is built only when NABP_SHIFT_ABORT_EN is defined.
module tb_nabp_shift_controller;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         sc_start = 1'b0;
    logic         sc_stall = 1'b0;
`ifdef NABP_SHIFT_ABORT_EN
    logic         sc_abort = 1'b0;
`endif
    logic         sh_kick;
    logic         sh_shift_en;
    logic         sh_done;
    logic         sh_busy;
    logic [W-1:0] sh_shift_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    nabp_shift_controller #(
        .kShiftCount(N),
        .kCountWidth(W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sc_start    (sc_start),
        .sc_stall    (sc_stall),
`ifdef NABP_SHIFT_ABORT_EN
        .sc_abort    (sc_abort),
`endif
        .sh_kick     (sh_kick),
        .sh_shift_en (sh_shift_en),
        .sh_done     (sh_done),
        .sh_busy     (sh_busy),
        .sh_shift_cnt(sh_shift_cnt)
    );

    typedef struct {
        logic rst_n;
        logic start;
        logic stall;
        logic chk;
        logic kick;
        logic shift;
        logic done;
        logic busy;
        int   cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, s, st, c, k, sh, d, b,
                                input int n);
        vec_t v;
        v.rst_n = r;
        v.start = s;
        v.stall = st;
        v.chk   = c;
        v.kick  = k;
        v.shift = sh;
        v.done  = d;
        v.busy  = b;
        v.cnt   = n;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Inputs change at the falling edge, and the outputs are sampled 1 ns later.
    task automatic drive(input logic r, s, st, ab);
        @(negedge clk);
        reset_n  = r;
        sc_start = s;
        sc_stall = st;
`ifdef NABP_SHIFT_ABORT_EN
        sc_abort = ab;
`else
        if (ab) $display("note: abort requested without abort build");
`endif
        #1;
        check("mutex", int'(sh_kick) + int'(sh_shift_en) + int'(sh_done) <= 1, 1);
    endtask

    task automatic expect_out(input string tag, input int k, sh, d, b, n);
        check({tag, ".kick"}, int'(sh_kick), k);
        check({tag, ".shift"}, int'(sh_shift_en), sh);
        check({tag, ".done"}, int'(sh_done), d);
        check({tag, ".busy"}, int'(sh_busy), b);
        check({tag, ".cnt"}, int'(sh_shift_cnt), n);
    endtask

    int shifts;
    bit exp_k, exp_s, exp_d, exp_b;

    initial begin
        // Reset is held with sc_start high; the start request must be ignored.
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        // Scenario A: one clean line.
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 0));
        for (int k = 0; k < N; k++)
            vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, k));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 8));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 8));
        // Scenario B: stall in cycles 4..6, and also in IDLE, KICK and DONE.
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 8));
        vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, 1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, 2));
        for (int k = 2; k < N; k++)
            vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, k));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 1, 8));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 8));
        // Scenario C: reset in cycle 5 of a line, then a fresh start.
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 8));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, k));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 3));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].start, vecs[i].stall, 1'b0);
            if (vecs[i].chk)
                expect_out($sformatf("vec%0d", i), vecs[i].kick, vecs[i].shift,
                           vecs[i].done, vecs[i].busy, vecs[i].cnt);
        end

        // With sc_start held high, lines repeat with one idle cycle between them.
        drive(0, 0, 0, 0);
        shifts = 0;
        for (int c = 0; c < 23; c++) begin
            drive(1, 1, 0, 0);
            exp_k = (c == 1 || c == 12);
            exp_d = (c == 10 || c == 21);
            exp_s = (c >= 2 && c <= 9) || (c >= 13 && c <= 20);
            exp_b = !(c == 0 || c == 11 || c == 22);
            check($sformatf("held%0d.kick", c), int'(sh_kick), int'(exp_k));
            check($sformatf("held%0d.shift", c), int'(sh_shift_en), int'(exp_s));
            check($sformatf("held%0d.done", c), int'(sh_done), int'(exp_d));
            check($sformatf("held%0d.busy", c), int'(sh_busy), int'(exp_b));
            if (sh_kick) shifts = 0;
            if (sh_shift_en) shifts++;
            if (sh_done) check("held.shifts_per_line", shifts, N);
        end

        // Start pulses in mid-line and in DONE are dropped; none of them is queued.
        drive(0, 0, 0, 0);
        for (int c = 0; c < 13; c++) begin
            drive(1, (c == 0 || c == 5 || c == 10), 0, 0);
            if (c == 5) expect_out("pulse5", 0, 1, 0, 1, 3);
            if (c == 10) expect_out("pulse10", 0, 0, 1, 1, 8);
            if (c == 11) expect_out("pulse11", 0, 0, 0, 0, 8);
            if (c == 12) expect_out("pulse12", 0, 0, 0, 0, 8);
        end

`ifdef NABP_SHIFT_ABORT_EN
        // Abort in cycle 5 keeps the partial count; an abort pulse in IDLE does nothing.
        drive(0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            drive(1, (c == 0), 0, (c == 5 || c == 8));
            if (c == 4) expect_out("abort4", 0, 1, 0, 1, 2);
            if (c == 5) expect_out("abort5", 0, 0, 0, 1, 3);
            if (c == 6) expect_out("abort6", 0, 0, 1, 1, 3);
            if (c == 7) expect_out("abort7", 0, 0, 0, 0, 3);
            if (c == 8) expect_out("abort8", 0, 0, 0, 0, 3);
            if (c == 9) expect_out("abort9", 0, 0, 0, 0, 3);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nabp_shift_controller.md
NABP_SHIFT_CONTROLLER -- requirements
Module: nabp_shift_controller

Interface
REQ-001 SHALL provide parameter kShiftCount, default 256: number of shift cycles per projection line, legal range 2..65535.
REQ-002 SHALL provide parameter kCountWidth, default 9: width of the shift counter; SHALL satisfy 2^kCountWidth > kShiftCount.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 sc_start  input  1  start request from state control; sampled only in IDLE.
REQ-006 sc_stall  input  1  downstream not ready; suppresses shifting while high.
REQ-007 sh_kick  output  1  one-cycle pulse opening a line; mapper/buffer consumers arm on it.
REQ-008 sh_shift_en  output  1  one shift this cycle.
REQ-009 sh_done  output  1  one-cycle pulse closing a line.
REQ-010 sh_busy  output  1  high in every state except IDLE.
REQ-011 sh_shift_cnt  output  kCountWidth  shifts completed in the current line.

Function
REQ-012 SHALL implement states IDLE, KICK, SHIFT, DONE as a registered state machine.
REQ-013 IDLE: sc_start=1 -> KICK next cycle; otherwise stay in IDLE.
REQ-014 KICK: sh_kick=1 for exactly this cycle; counter cleared to 0; -> SHIFT unconditionally.
REQ-015 SHIFT: sh_shift_en = !sc_stall, combinational from the current state and sc_stall.
REQ-016 SHIFT: each cycle with sh_shift_en=1, counter increments by 1.
REQ-017 SHIFT: sh_shift_en=1 with counter = kShiftCount-1 -> DONE; counter reaches kShiftCount.
REQ-018 Exactly kShiftCount sh_shift_en cycles SHALL occur between sh_kick and sh_done, whatever the stall pattern.
REQ-019 DONE: sh_done=1 for exactly this cycle; -> IDLE unconditionally.
REQ-020 sh_kick, sh_shift_en and sh_done SHALL be mutually exclusive in every cycle.
REQ-021 Latency: sc_start at cycle t with no stall gives:
- sh_kick at t+1;
- shifts at t+2..t+1+kShiftCount;
- sh_done at t+2+kShiftCount.
REQ-022 sc_start outside IDLE SHALL be ignored, not queued.
REQ-023 sc_start held high through DONE SHALL start a new line on the first IDLE cycle: one idle gap cycle between lines.
REQ-024 sc_stall in IDLE, KICK or DONE SHALL have no effect.
REQ-025 sh_shift_cnt SHALL hold its final value in DONE and IDLE until the next KICK.
REQ-026 The counter SHALL never exceed kShiftCount and SHALL never wrap.

Reset
REQ-027 reset_n=0 at an edge SHALL force IDLE and clear the counter; all outputs read 0 after that edge.
REQ-028 Reset in KICK or SHIFT SHALL abandon the line without a sh_done pulse.
REQ-029 sc_start with reset_n=0 SHALL be ignored.

Configuration
REQ-030 Macro NABP_SHIFT_ABORT_EN SHALL, when defined, add input sc_abort (1 bit).
- sc_abort=1 in KICK or SHIFT: -> DONE next cycle, with no sh_shift_en in that cycle.
- sh_done pulses normally; sh_shift_cnt holds the partial count.
- sc_abort in IDLE or DONE: ignored.
- sc_abort has priority over the REQ-017 terminal transition.
REQ-031 Without NABP_SHIFT_ABORT_EN, the port SHALL be absent and the behaviour SHALL be exactly REQ-012..REQ-029.

Verification
REQ-032 kShiftCount=8, no stall, sc_start pulse at cycle 0 -> kick@1, shift_en@2..9, done@10, busy@1..10, cnt=8 after the line.
REQ-033 kShiftCount=8, sc_stall high cycles 4..6 -> shift_en low @4..6, still 8 shifts total, done@13.
REQ-034 sc_start held high continuously -> repeated lines (kick@1, done@10, IDLE@11, kick@12); sc_start pulses mid-line produce nothing.
REQ-035 reset_n low at cycle 5 mid-SHIFT -> state IDLE, cnt=0, no done pulse; next sc_start gives a normal line.
REQ-036 NABP_SHIFT_ABORT_EN defined, sc_abort@5 -> no shift_en@5, done@6, cnt=3; abort pulse in IDLE -> no effect.
REQ-037 All scenarios: assert kick/shift_en/done mutual exclusion and count of shift_en pulses per line == kShiftCount (non-aborted lines).
